spi_master_param: RTL and testbench

- Parametrised successor to the 8-bit fixed-mode SPI master.
- Generalised in word width, SCK divide ratio and number of chip selects.
- Adds runtime-selectable SPI mode (CPOL/CPHA), LSB/MSB-first ordering and a chip-select hold option for multi-word bursts.
- Sits between avionics sensor/peripheral controllers and the off-chip SPI bus, with one transaction per start request.

---
 rtl/spi_master_param_if.sv | 34 +++
 rtl/spi_master_param.sv | 158 +++++++++++++++
 tb/tb_spi_master_param.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_param_if.sv
// SPI master bundle: request/mode inputs, serial pins, received word and status.
// Ports: start/data_in/cpol/cpha/cs_sel/cs_hold/miso in; mosi/sck/cs_n/data_out/busy/new_data out.
// Latency/backpressure: none here; timing and busy/start handshake live in spi_master_param.
interface spi_master_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CS     = 1,
   parameter int CS_W       = 1
) ();
   logic                  start;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  cpol;
   logic                  cpha;
   logic [CS_W-1:0]       cs_sel;
   logic                  cs_hold;
   logic                  miso;
   logic                  mosi;
   logic                  sck;
   logic [NUM_CS-1:0]     cs_n;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;
   logic                  new_data;

   // master: the SPI engine itself
   modport master (
      input  start, data_in, cpol, cpha, cs_sel, cs_hold, miso,
      output mosi, sck, cs_n, data_out, busy, new_data
   );

   // slave: the controller/peripheral side driving requests and miso
   modport slave (
      output start, data_in, cpol, cpha, cs_sel, cs_hold, miso,
      input  mosi, sck, cs_n, data_out, busy, new_data
   );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master, runtime CPOL/CPHA, MSB/LSB order, CS hold for bursts.
// Latency: busy high CLK_DIV*(2*DATA_WIDTH+2) cycles; new_data pulses as busy drops.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
// Ports: clk, rst (async active-low), bus (master modport of spi_master_param_if).
module spi_master_param #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2,
   parameter int NUM_CS     = 1,
   parameter int CS_W       = 1,
   parameter bit MSB_FIRST  = 1'b1
) (
   input logic                clk,
   input logic                rst,
   spi_master_param_if.master bus
);
   localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGES  = 2 * DATA_WIDTH;
   localparam int ECNT_W = $clog2(EDGES + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [ECNT_W-1:0]     ecnt;
   logic [DATA_WIDTH-1:0] tx;
   logic [DATA_WIDTH-1:0] rx;
   logic                  cpol_q;
   logic                  cpha_q;
   logic                  hold_q;
   logic                  cs_held;
   logic [CS_W-1:0]       cs_q;

   logic                  sck_r;
   logic                  mosi_r;
   logic                  busy_r;
   logic                  new_data_r;
   logic [NUM_CS-1:0]     cs_n_r;
   logic [DATA_WIDTH-1:0] data_out_r;

   assign bus.sck      = sck_r;
   assign bus.mosi     = mosi_r;
   assign bus.busy     = busy_r;
   assign bus.new_data = new_data_r;
   assign bus.cs_n     = cs_n_r;
   assign bus.data_out = data_out_r;

   function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] v);
      return MSB_FIRST ? {v[DATA_WIDTH-2:0], 1'b0} : {1'b0, v[DATA_WIDTH-1:1]};
   endfunction

   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] v);
      return MSB_FIRST ? v[DATA_WIDTH-1] : v[0];
   endfunction

   function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] v,
                                                       input logic b);
      return MSB_FIRST ? {v[DATA_WIDTH-2:0], b} : {b, v[DATA_WIDTH-1:1]};
   endfunction

   // A held CS pins the slave for the whole burst, so cs_sel is not consulted then.
   logic [CS_W-1:0]   sel_idx;
   logic              sel_ok;
   logic              half_done;
   logic [ECNT_W-1:0] ecnt_nxt;
   logic              leading;
   logic              do_edge;

   assign sel_idx   = cs_held ? cs_q : bus.cs_sel;
   assign sel_ok    = cs_held || (32'(bus.cs_sel) < NUM_CS);
   assign half_done = (cnt == CNT_W'(CLK_DIV - 1));
   assign ecnt_nxt  = ecnt + 1'b1;
   assign leading   = ecnt_nxt[0];
   // SCK edges fall on the SETUP->SHIFT boundary and every half-period boundary
   // inside SHIFT until all 2*DATA_WIDTH edges are out; the last half-period then
   // sits at the idle level before HOLD.
   assign do_edge   = half_done &&
                      ((state == SETUP) || ((state == SHIFT) && (ecnt != ECNT_W'(EDGES))));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         ecnt       <= '0;
         tx         <= '0;
         rx         <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         hold_q     <= 1'b0;
         cs_held    <= 1'b0;
         cs_q       <= '0;
         sck_r      <= 1'b0;
         mosi_r     <= 1'b0;
         busy_r     <= 1'b0;
         new_data_r <= 1'b0;
         cs_n_r     <= '1;
         data_out_r <= '0;
      end else begin
         new_data_r <= 1'b0;
         if (state == IDLE) cnt <= '0;
         else               cnt <= half_done ? '0 : cnt + 1'b1;

         case (state)
            IDLE: begin
               sck_r <= cpol_q;
               if (bus.start && sel_ok) begin
                  cpol_q <= bus.cpol;
                  cpha_q <= bus.cpha;
                  hold_q <= bus.cs_hold;
                  cs_q   <= sel_idx;
                  sck_r  <= bus.cpol;
                  cs_n_r <= ~(NUM_CS'(1) << sel_idx);
                  busy_r <= 1'b1;
                  tx     <= bus.data_in;
                  rx     <= '0;
                  ecnt   <= '0;
                  // CPHA=0 needs the first bit on the wire for the whole SETUP.
                  if (!bus.cpha) mosi_r <= out_bit(bus.data_in);
                  state  <= SETUP;
               end
            end
            SETUP: if (half_done) state <= SHIFT;
            SHIFT: if (half_done && (ecnt == ECNT_W'(EDGES))) state <= HOLD;
            HOLD: begin
               if (half_done) begin
                  state      <= IDLE;
                  busy_r     <= 1'b0;
                  new_data_r <= 1'b1;
                  data_out_r <= rx;
                  cs_held    <= hold_q;
                  if (!hold_q) cs_n_r <= '1;
               end
            end
            default: state <= IDLE;
         endcase

         if (do_edge) begin
            sck_r <= ~sck_r;
            ecnt  <= ecnt_nxt;
            if (leading) begin
               if (cpha_q) begin
                  mosi_r <= out_bit(tx);
                  tx     <= shift_tx(tx);
               end else begin
                  rx <= shift_rx(rx, bus.miso);
               end
            end else begin
               if (cpha_q) begin
                  rx <= shift_rx(rx, bus.miso);
               end else if (ecnt_nxt != ECNT_W'(EDGES)) begin
                  // No update after the final trailing edge: the line just holds.
                  tx     <= shift_tx(tx);
                  mosi_r <= out_bit(shift_tx(tx));
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two instances (8-bit/div2/4 CS MSB-first and
// 16-bit/div4/1 CS LSB-first); directed words, scoreboard queue per instance
// checked by an independent new_data monitor.
module tb_spi_master_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a;
   logic rst_b;
   logic loop_a;
   logic slave_en;
   logic miso_slv;
   logic [7:0] slv_word;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   spi_master_param_if #(.DATA_WIDTH(8),  .NUM_CS(4), .CS_W(3)) bus_a ();
   spi_master_param_if #(.DATA_WIDTH(16), .NUM_CS(1), .CS_W(1)) bus_b ();

   spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(4), .CS_W(3), .MSB_FIRST(1'b1))
      dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

   spi_master_param #(.DATA_WIDTH(16), .CLK_DIV(4), .NUM_CS(1), .CS_W(1), .MSB_FIRST(1'b0))
      dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

   assign bus_a.miso = loop_a ? bus_a.mosi : miso_slv;
   assign bus_b.miso = bus_b.mosi;

   // CPHA=1 slave returning 0xA5 MSB-first: shifts a new bit out on each
   // leading (falling, CPOL=1) edge; reloads whenever it is (re)enabled or idle.
   always @(negedge bus_a.sck or posedge slave_en) begin
      if (slave_en && bus_a.busy) begin
         miso_slv = slv_word[7];
         slv_word = {slv_word[6:0], 1'b0};
      end else begin
         slv_word = 8'hA5;
         miso_slv = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: count busy cycles, pop expectation on each new_data.
   int busy_cnt_a = 0;
   int busy_cnt_b = 0;
   logic prev_nd_a = 1'b0;
   logic prev_nd_b = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (bus_a.new_data) begin
         chk("a_new_data_single_cycle", prev_nd_a, 1'b0);
         chk("a_busy_low_at_new_data", bus_a.busy, 1'b0);
         if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_new_data: data_out=0x%0h, none expected", bus_a.data_out);
         end else begin
            e = qa.pop_front();
            chk("a_data_out", bus_a.data_out, e.data);
            chk("a_busy_cycles", busy_cnt_a, e.cyc);
         end
         busy_cnt_a = 0;
      end else if (bus_a.busy) busy_cnt_a++;
      else busy_cnt_a = 0;
      prev_nd_a = bus_a.new_data;
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus_b.new_data) begin
         chk("b_new_data_single_cycle", prev_nd_b, 1'b0);
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_new_data: data_out=0x%0h, none expected", bus_b.data_out);
         end else begin
            e = qb.pop_front();
            chk("b_data_out", bus_b.data_out, e.data);
            chk("b_busy_cycles", busy_cnt_b, e.cyc);
         end
         busy_cnt_b = 0;
      end else if (bus_b.busy) busy_cnt_b++;
      else busy_cnt_b = 0;
      prev_nd_b = bus_b.new_data;
   end

   // Issue one word on instance A, scramble inputs while busy, optionally
   // re-pulse start at iteration 'poke', and watch until new_data.
   task automatic run_a(input logic [7:0] d, input logic pol, input logic pha,
                        input logic [2:0] sel, input logic hold, input logic [3:0] cs_exp,
                        input int poke, output int rises, output logic [7:0] cap,
                        output int cs_bad);
      logic prev_sck;
      bit   done;
      rises  = 0;
      cap    = '0;
      cs_bad = 0;
      done   = 1'b0;
      @(negedge clk);
      bus_a.data_in = d;
      bus_a.cpol    = pol;
      bus_a.cpha    = pha;
      bus_a.cs_sel  = sel;
      bus_a.cs_hold = hold;
      bus_a.start   = 1'b1;
      @(negedge clk);
      bus_a.start   = 1'b0;
      bus_a.data_in = ~d;
      bus_a.cpol    = ~pol;
      bus_a.cpha    = ~pha;
      bus_a.cs_sel  = 3'd1;
      bus_a.cs_hold = ~hold;
      prev_sck = bus_a.sck;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         bus_a.start = (k == poke);
         if (bus_a.new_data) done = 1'b1;
         else begin
            if (bus_a.busy && (bus_a.cs_n !== cs_exp)) cs_bad++;
            if (!prev_sck && bus_a.sck) begin
               cap = {cap[6:0], bus_a.mosi};
               rises++;
            end
         end
         prev_sck = bus_a.sck;
      end
      bus_a.start = 1'b0;
      chk("a_transfer_done", done, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          rises;
      logic [7:0]  cap;
      int          cs_bad;
      bit          seen;
      logic        prev_sck;
      logic [15:0] cap_b;
      int          rises_b;
      int          bad_b;
      bit          done_b;

      rst_a = 1'b0;
      rst_b = 1'b0;
      loop_a = 1'b1;
      slave_en = 1'b0;
      bus_a.start = 1'b0; bus_a.data_in = '0; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0;
      bus_a.cs_sel = '0;  bus_a.cs_hold = 1'b0;
      bus_b.start = 1'b0; bus_b.data_in = '0; bus_b.cpol = 1'b0; bus_b.cpha = 1'b0;
      bus_b.cs_sel = '0;  bus_b.cs_hold = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("a_reset_sck", bus_a.sck, 1'b0);
      chk("a_reset_mosi", bus_a.mosi, 1'b0);
      chk("a_reset_cs_n", bus_a.cs_n, 4'hF);
      chk("a_reset_data_out", bus_a.data_out, 8'h00);
      chk("a_reset_busy", bus_a.busy, 1'b0);
      chk("a_reset_new_data", bus_a.new_data, 1'b0);
      chk("b_reset_cs_n", bus_b.cs_n, 1'b1);
      chk("b_reset_busy", bus_b.busy, 1'b0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0 loopback 0x54: mosi 0,1,0,1,0,1,0,0 at the 8 rising edges
      qa.push_back(exp_t'{16'h0054, 36});
      run_a(8'h54, 1'b0, 1'b0, 3'd0, 1'b0, 4'b1110, -1, rises, cap, cs_bad);
      chk("m0_sck_rises", rises, 8);
      chk("m0_mosi_sequence", cap, 8'h54);
      chk("m0_cs_during", cs_bad, 0);
      chk("m0_cs_released", bus_a.cs_n, 4'hF);
      chk("m0_sck_idle", bus_a.sck, 1'b0);

      // Mode 3 with slave returning 0xA5, master sends 0x3C
      loop_a = 1'b0;
      slave_en = 1'b1;
      qa.push_back(exp_t'{16'h00A5, 36});
      run_a(8'h3C, 1'b1, 1'b1, 3'd0, 1'b0, 4'b1110, -1, rises, cap, cs_bad);
      chk("m3_sck_rises", rises, 8);
      chk("m3_mosi_sequence", cap, 8'h3C);
      chk("m3_cs_during", cs_bad, 0);
      @(negedge clk);
      chk("m3_sck_idle_high", bus_a.sck, 1'b1);
      chk("m3_cs_released", bus_a.cs_n, 4'hF);
      slave_en = 1'b0;
      loop_a = 1'b1;

      // Burst on slave 2: held CS across both words, second cs_sel ignored
      qa.push_back(exp_t'{16'h0081, 36});
      run_a(8'h81, 1'b0, 1'b0, 3'd2, 1'b1, 4'b1011, -1, rises, cap, cs_bad);
      chk("burst1_cs_during", cs_bad, 0);
      chk("burst1_mosi_sequence", cap, 8'h81);
      chk("burst1_cs_held", bus_a.cs_n, 4'b1011);
      qa.push_back(exp_t'{16'h007E, 36});
      run_a(8'h7E, 1'b0, 1'b0, 3'd0, 1'b0, 4'b1011, -1, rises, cap, cs_bad);
      chk("burst2_cs_during", cs_bad, 0);
      chk("burst2_cs_released", bus_a.cs_n, 4'hF);

      // start while busy, then start with cs_sel=5 in IDLE: both ignored
      qa.push_back(exp_t'{16'h000F, 36});
      run_a(8'h0F, 1'b0, 1'b0, 3'd1, 1'b0, 4'b1101, 5, rises, cap, cs_bad);
      chk("poke_cs_during", cs_bad, 0);
      @(negedge clk);
      bus_a.data_in = 8'hEE; bus_a.cpol = 1'b0; bus_a.cpha = 1'b0;
      bus_a.cs_sel = 3'd5;   bus_a.cs_hold = 1'b0; bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      seen = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (bus_a.busy || (bus_a.cs_n !== 4'hF)) seen = 1'b1;
      end
      chk("bad_sel_ignored", seen, 1'b0);

      // Reset at cycle 10 of a CPOL=1 transfer: immediate abort, no new_data
      @(negedge clk);
      bus_a.data_in = 8'hC3; bus_a.cpol = 1'b1; bus_a.cpha = 1'b0;
      bus_a.cs_sel = 3'd3;   bus_a.cs_hold = 1'b0; bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_busy_before", bus_a.busy, 1'b1);
      rst_a = 1'b0;
      #1;
      chk("abort_cs_n", bus_a.cs_n, 4'hF);
      chk("abort_sck", bus_a.sck, 1'b0);
      chk("abort_busy", bus_a.busy, 1'b0);
      chk("abort_mosi", bus_a.mosi, 1'b0);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (bus_a.busy || bus_a.new_data) seen = 1'b1;
      end
      chk("abort_quiet_after", seen, 1'b0);
      qa.push_back(exp_t'{16'h005A, 36});
      run_a(8'h5A, 1'b0, 1'b0, 3'd3, 1'b0, 4'b0111, -1, rises, cap, cs_bad);
      chk("post_reset_mosi_sequence", cap, 8'h5A);
      chk("post_reset_cs_during", cs_bad, 0);

      // 16-bit, CLK_DIV=4, LSB-first loopback of 0x1234
      qb.push_back(exp_t'{16'h1234, 136});
      @(negedge clk);
      bus_b.data_in = 16'h1234; bus_b.cpol = 1'b0; bus_b.cpha = 1'b0;
      bus_b.cs_sel = 1'b0;      bus_b.cs_hold = 1'b0; bus_b.start = 1'b1;
      @(negedge clk);
      bus_b.start = 1'b0;
      bus_b.data_in = 16'hFFFF;
      chk("b_busy_started", bus_b.busy, 1'b1);
      chk("b_first_mosi", bus_b.mosi, 1'b0);
      cap_b = '0; rises_b = 0; bad_b = 0; done_b = 1'b0;
      prev_sck = bus_b.sck;
      for (int k = 0; k < 400 && !done_b; k++) begin
         @(negedge clk);
         if (bus_b.new_data) done_b = 1'b1;
         else begin
            if (bus_b.busy && (bus_b.cs_n !== 1'b0)) bad_b++;
            if (!prev_sck && bus_b.sck) begin
               cap_b = {bus_b.mosi, cap_b[15:1]};
               rises_b++;
            end
         end
         prev_sck = bus_b.sck;
      end
      chk("b_transfer_done", done_b, 1'b1);
      chk("b_sck_rises", rises_b, 16);
      chk("b_mosi_sequence", cap_b, 16'h1234);
      chk("b_cs_during", bad_b, 0);
      chk("b_cs_released", bus_b.cs_n, 1'b1);

      repeat (5) @(negedge clk);
      chk("a_scoreboard_empty", qa.size(), 0);
      chk("b_scoreboard_empty", qb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
